// File: rtl/elixirchip_es1_spu_op_lut_pkg.sv
// Shared types and helpers for the runtime-writable SPU LUT op.
package elixirchip_es1_spu_op_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } lut_state_e;

    // Table write pointer increment, wrapping at the last entry
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned table_size);
        return (addr == table_size - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_lut_ram.sv
// LUT storage: register array with reset contents, one write port and a
// latency-1 read port with clear/valid.
module elixirchip_es1_spu_op_lut_ram #(
    parameter int unsigned                      TABLE_SIZE  = 64,
    parameter int unsigned                      ADDR_BITS   = $clog2(TABLE_SIZE),
    parameter int unsigned                      DATA_BITS   = 8,
    parameter logic [TABLE_SIZE*DATA_BITS-1:0]  INIT_VALUES = '0,
    parameter logic [DATA_BITS-1:0]             CLEAR_DATA  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    input  logic                 rclear,
    input  logic                 rvalid,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int unsigned AW1 = ADDR_BITS + 1;

    logic [DATA_BITS-1:0] mem [TABLE_SIZE];
    logic                 raddr_ok_c;

    assign raddr_ok_c = ({1'b0, raddr} < AW1'(TABLE_SIZE));

    // Table contents; reset restores the initial image
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
                mem[i] <= INIT_VALUES[i*DATA_BITS +: DATA_BITS];
            end
        end else if (cke && we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port samples the pre-write contents, so same-cycle RW returns old data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= CLEAR_DATA;
        end else if (cke) begin
            if (rclear) begin
                rdata <= CLEAR_DATA;
            end else if (rvalid) begin
                rdata <= raddr_ok_c ? mem[raddr] : CLEAR_DATA;
            end
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_lut_loader.sv
// Runtime-loadable SPU LUT op: start/count load FSM feeding the table from a
// valid/ready word stream, with the constant-LUT read port semantics.
module elixirchip_es1_spu_op_lut_loader
    import elixirchip_es1_spu_op_lut_pkg::*;
#(
    parameter int unsigned                      TABLE_SIZE  = 64,
    parameter int unsigned                      ADDR_BITS   = $clog2(TABLE_SIZE),
    parameter int unsigned                      DATA_BITS   = 8,
    parameter logic [TABLE_SIZE*DATA_BITS-1:0]  INIT_VALUES = '0,
    parameter logic [DATA_BITS-1:0]             CLEAR_DATA  = '0,
    parameter string                            DEVICE      = "RTL",
    parameter string                            SIMULATION  = "false",
    parameter string                            DEBUG       = "false"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic                 s_start,
    input  logic [ADDR_BITS-1:0] s_start_addr,
    input  logic [ADDR_BITS:0]   s_count,
    input  logic                 s_abort,
    input  logic [DATA_BITS-1:0] s_wdata,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic                 busy,
    output logic                 done,
    input  logic [ADDR_BITS-1:0] s_addr,
    input  logic                 s_clear,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data
);

    localparam int unsigned         CNT_BITS  = ADDR_BITS + 1;
    localparam logic [CNT_BITS-1:0] TABLE_CNT = CNT_BITS'(TABLE_SIZE);

    lut_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [CNT_BITS-1:0]   remain_q, remain_d;
    logic [ADDR_BITS-1:0]  start_addr_c;
    logic [CNT_BITS-1:0]   start_count_c;
    logic                  accept_c;

    // Out-of-range start address wraps; oversize counts clamp to one full table
    assign start_addr_c  = ({1'b0, s_start_addr} >= TABLE_CNT)
                         ? (s_start_addr - ADDR_BITS'(TABLE_SIZE)) : s_start_addr;
    assign start_count_c = (s_count > TABLE_CNT) ? TABLE_CNT : s_count;

    // Ready is combinational so a word can land on the first LOAD cycle
    assign s_wready = cke && (state_q == ST_LOAD);
    assign accept_c = s_wready && s_wvalid && !s_abort;

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        remain_d  = remain_q;
        case (state_q)
            ST_IDLE: begin
                if (s_start) begin
                    if (s_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_LOAD;
                        wr_addr_d = start_addr_c;
                        remain_d  = start_count_c;
                    end
                end
            end
            ST_LOAD: begin
                if (s_abort) begin
                    state_d = ST_IDLE;
                end else if (accept_c) begin
                    wr_addr_d = ADDR_BITS'(next_addr(32'(wr_addr_q), TABLE_SIZE));
                    remain_d  = remain_q - CNT_BITS'(1);
                    if (remain_q == CNT_BITS'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            remain_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (cke) begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            remain_q  <= remain_d;
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
        end
    end

    elixirchip_es1_spu_op_lut_ram #(
        .TABLE_SIZE  (TABLE_SIZE),
        .ADDR_BITS   (ADDR_BITS),
        .DATA_BITS   (DATA_BITS),
        .INIT_VALUES (INIT_VALUES),
        .CLEAR_DATA  (CLEAR_DATA)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .we      (accept_c),
        .waddr   (wr_addr_q),
        .wdata   (s_wdata),
        .raddr   (s_addr),
        .rclear  (s_clear),
        .rvalid  (s_valid),
        .rdata   (m_data)
    );

    // Simulation-only pointer sanity checks for the RTL model
    if (SIMULATION == "true" && DEBUG == "true" && DEVICE == "RTL") begin : g_debug_check
        always_ff @(posedge clk) begin
            if (reset_n && cke) begin
                assert ({1'b0, wr_addr_q} < TABLE_CNT);
                assert (remain_q <= TABLE_CNT);
            end
        end
    end

endmodule
